// File: rtl/ipsxe_floating_point_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ipsxe_floating_point_pkg
// Brief   : Shared constants for the invsqrt floating-point datapath blocks.
// Revision: v1.0 - initial release
//------------------------------------------------------------------------------
package ipsxe_floating_point_pkg;

  localparam int unsigned C_LATENCY_MIN = 0;
  localparam int unsigned C_LATENCY_MAX = 3;

  // Default widths of the invsqrt low-part correction slice
  localparam int unsigned C_INVSQRT_XW = 28;
  localparam int unsigned C_INVSQRT_YW = 18;
  localparam int unsigned C_INVSQRT_ZW = 38;
  localparam int unsigned C_INVSQRT_PW = 48;

endpackage
`default_nettype wire

// File: rtl/ipsxe_floating_point_pipe_reg_v1_0.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ipsxe_floating_point_pipe_reg_v1_0
// Brief   : Bypassable pipeline register with async reset and clock enable.
// Revision: v1.0 - initial release
//------------------------------------------------------------------------------
module ipsxe_floating_point_pipe_reg_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter bit          EN    = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (EN) begin : g_reg
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_q <= '0;
        else if (i_ce) r_q <= i_d;
      end
      assign o_q = r_q;
    end else begin : g_bypass
      // Clock, reset and enable have no effect on a bypassed stage
      logic w_unused_ctrl;
      assign w_unused_ctrl = &{1'b0, i_clk, i_rst, i_ce};
      assign o_q = i_d;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ipsxe_floating_point_lo_madd_pipe_v1_0.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ipsxe_floating_point_lo_madd_pipe_v1_0
// Brief   : Pipelined signed multiply-add, o_p = (Z << Z_SHIFT) +/- X*Y.
// Revision: v1.0 - initial release
//------------------------------------------------------------------------------
module ipsxe_floating_point_lo_madd_pipe_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned XW      = C_INVSQRT_XW,
  parameter int unsigned YW      = C_INVSQRT_YW,
  parameter int unsigned ZW      = C_INVSQRT_ZW,
  parameter int unsigned Z_SHIFT = 0,
  parameter int unsigned PW      = C_INVSQRT_PW,
  parameter int unsigned LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic          i_valid,
  input  logic          i_sub,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [ZW-1:0] i_z,
  output logic          o_valid,
  output logic [PW-1:0] o_p,
  output logic          o_ovf
);

  localparam int unsigned C_MW  = XW + YW;
  localparam int unsigned C_S1W = 1 + ZW + YW + XW;
  localparam int unsigned C_S2W = 1 + (PW + 1) + C_MW;

  generate
    if (PW < XW + YW + 1) begin : g_chk_pw
      $error("PW must be at least XW+YW+1");
    end
    if (Z_SHIFT + ZW > PW) begin : g_chk_shift
      $error("Z_SHIFT+ZW must not exceed PW");
    end
    if (LATENCY > C_LATENCY_MAX) begin : g_chk_lat
      $error("LATENCY must be in 0..3");
    end
  endgenerate

  // Stage 1: raw operands
  logic [C_S1W-1:0] w_s1_d, r_s1_q;
  logic             r_s1_v;

  assign w_s1_d = {i_sub, i_z, i_y, i_x};

  ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(C_S1W), .EN(LATENCY >= 1)) u_s1_data (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_d(w_s1_d), .o_q(r_s1_q)
  );
  ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(1), .EN(LATENCY >= 1)) u_s1_valid (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_d(i_valid), .o_q(r_s1_v)
  );

  logic [XW-1:0]   w_s1_x;
  logic [YW-1:0]   w_s1_y;
  logic [ZW-1:0]   w_s1_z;
  logic            w_s1_sub;
  logic [C_MW-1:0] w_prod;
  logic [PW:0]     w_zz;

  assign w_s1_x   = r_s1_q[XW-1:0];
  assign w_s1_y   = r_s1_q[XW +: YW];
  assign w_s1_z   = r_s1_q[XW+YW +: ZW];
  assign w_s1_sub = r_s1_q[C_S1W-1];
  assign w_prod   = {{YW{1'b0}}, w_s1_x} * {{XW{1'b0}}, w_s1_y};
  assign w_zz     = {{(PW+1-ZW){1'b0}}, w_s1_z} << Z_SHIFT;

  // Stage 2: product and aligned addend
  logic [C_S2W-1:0] w_s2_d, r_s2_q;
  logic             r_s2_v;

  assign w_s2_d = {w_s1_sub, w_zz, w_prod};

  ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(C_S2W), .EN(LATENCY >= 2)) u_s2_data (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_d(w_s2_d), .o_q(r_s2_q)
  );
  ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(1), .EN(LATENCY >= 2)) u_s2_valid (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_d(r_s1_v), .o_q(r_s2_v)
  );

  logic [C_MW-1:0] w_s2_prod;
  logic [PW:0]     w_s2_zz;
  logic            w_s2_sub;
  logic [PW:0]     w_prod_ext;
  logic [PW:0]     w_sum;

  assign w_s2_prod  = r_s2_q[C_MW-1:0];
  assign w_s2_zz    = r_s2_q[C_MW +: PW+1];
  assign w_s2_sub   = r_s2_q[C_S2W-1];
  assign w_prod_ext = {{(PW+1-C_MW){1'b0}}, w_s2_prod};
  // One guard bit above PW exposes signed overflow as a top-two-bit mismatch
  assign w_sum      = w_s2_sub ? (w_s2_zz - w_prod_ext) : (w_s2_zz + w_prod_ext);

  // Stage 3: result
  logic [PW:0] w_s3_d, r_s3_q;
  logic        r_s3_v;

  assign w_s3_d = {w_sum[PW] ^ w_sum[PW-1], w_sum[PW-1:0]};

  ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(PW+1), .EN(LATENCY == 3)) u_s3_data (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_d(w_s3_d), .o_q(r_s3_q)
  );
  ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(1), .EN(LATENCY == 3)) u_s3_valid (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_d(r_s2_v), .o_q(r_s3_v)
  );

  assign o_valid = r_s3_v;
  assign o_ovf   = r_s3_q[PW];
  assign o_p     = r_s3_q[PW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_lo_madd_pipe_v1_0.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_ipsxe_floating_point_lo_madd_pipe_v1_0
// Brief   : Scoreboard bench for the multiply-add pipe, LATENCY 0..3 side by side.
// Revision: v1.0 - initial release
//------------------------------------------------------------------------------
module tb_ipsxe_floating_point_lo_madd_pipe_v1_0;

  typedef struct {
    logic [47:0] p;
    logic        o;
    int          cyc;
  } exp_t;

  localparam int ZS [4] = '{0, 4, 0, 10};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic        v   = 1'b0;
  logic        s   = 1'b0;
  logic [27:0] x   = '0;
  logic [17:0] y   = '0;
  logic [37:0] z   = '0;

  logic [47:0] op [4];
  logic        ov [4];
  logic        oo [4];

  exp_t sb [4][$];
  int   ecyc   = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_lo_madd_pipe_v1_0 #(.Z_SHIFT(0), .LATENCY(0)) u_l0 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(v), .i_sub(s), .i_x(x), .i_y(y), .i_z(z),
    .o_valid(ov[0]), .o_p(op[0]), .o_ovf(oo[0]));
  ipsxe_floating_point_lo_madd_pipe_v1_0 #(.Z_SHIFT(4), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(v), .i_sub(s), .i_x(x), .i_y(y), .i_z(z),
    .o_valid(ov[1]), .o_p(op[1]), .o_ovf(oo[1]));
  ipsxe_floating_point_lo_madd_pipe_v1_0 #(.Z_SHIFT(0), .LATENCY(2)) u_l2 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(v), .i_sub(s), .i_x(x), .i_y(y), .i_z(z),
    .o_valid(ov[2]), .o_p(op[2]), .o_ovf(oo[2]));
  ipsxe_floating_point_lo_madd_pipe_v1_0 #(.Z_SHIFT(10), .LATENCY(3)) u_l3 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(v), .i_sub(s), .i_x(x), .i_y(y), .i_z(z),
    .o_valid(ov[3]), .o_p(op[3]), .o_ovf(oo[3]));

  function automatic logic [48:0] ref_sum(input logic is, input logic [27:0] ix,
                                          input logic [17:0] iy, input logic [37:0] iz,
                                          input int zs);
    logic [48:0] zz, pr;
    zz = {11'd0, iz} << zs;
    pr = {21'd0, ix} * {31'd0, iy};
    return is ? (zz - pr) : (zz + pr);
  endfunction

  // Enabled-cycle index: an accepted sample surfaces LATENCY enabled cycles later
  always @(posedge clk) if (!rst && ce) ecyc = ecyc + 1;

  // hi/hp/ho replace the model value of one instance with a hand-computed one
  task automatic issue(input logic iv, input logic is, input logic [27:0] ix,
                       input logic [17:0] iy, input logic [37:0] iz, input logic ice,
                       input int hi, input logic [47:0] hp, input logic ho);
    logic [48:0] sm;
    exp_t        e;
    @(posedge clk); #1;
    v = iv; s = is; x = ix; y = iy; z = iz; ce = ice;
    if (iv && ice) begin
      for (int i = 0; i < 4; i++) begin
        sm    = ref_sum(is, ix, iy, iz, ZS[i]);
        e.p   = sm[47:0];
        e.o   = sm[48] ^ sm[47];
        e.cyc = ecyc + i;
        if (i == hi) begin
          e.p = hp;
          e.o = ho;
        end
        sb[i].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(1'b0, 1'b0, '0, '0, '0, 1'b1, -1, '0, 1'b0);
  endtask

  task automatic check_zero(input string tag, input int lo);
    for (int i = lo; i < 4; i++) begin
      n_cmp++;
      if (ov[i] !== 1'b0 || op[i] !== 48'd0 || oo[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s[L%0d]: got valid=%b p=%h ovf=%b, want all zero", tag, i, ov[i], op[i], oo[i]);
      end
    end
  endtask

  // Monitor: pops on each consumed valid output, and checks held outputs under ce=0
  logic [47:0] snap_p [4];
  logic        snap_v [4];
  logic        snap_o [4];
  logic        prev_ok = 1'b0;
  logic        prev_ce = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      for (int i = 1; i < 4; i++) begin
        if (prev_ok && !prev_ce) begin
          n_cmp++;
          if (ov[i] !== snap_v[i] || op[i] !== snap_p[i] || oo[i] !== snap_o[i]) begin
            n_fail++;
            $display("FAIL hold[L%0d]: got valid=%b p=%h ovf=%b, want valid=%b p=%h ovf=%b",
                     i, ov[i], op[i], oo[i], snap_v[i], snap_p[i], snap_o[i]);
          end
        end
      end
      if (ce) begin
        for (int i = 0; i < 4; i++) begin
          if (ov[i] === 1'b1) begin
            n_cmp++;
            if (sb[i].size() == 0) begin
              n_fail++;
              $display("FAIL unexpected[L%0d]: got valid output p=%h at cycle %0d, want none", i, op[i], ecyc);
            end else begin
              e = sb[i].pop_front();
              if (op[i] !== e.p || oo[i] !== e.o || ecyc != e.cyc) begin
                n_fail++;
                $display("FAIL result[L%0d]: got p=%h ovf=%b cyc=%0d, want p=%h ovf=%b cyc=%0d",
                         i, op[i], oo[i], ecyc, e.p, e.o, e.cyc);
              end
            end
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        snap_p[i] = op[i];
        snap_v[i] = ov[i];
        snap_o[i] = oo[i];
      end
      prev_ce = ce;
      prev_ok = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state", 0);
    rst = 1'b0;
    #1;
    check_zero("after_release", 0);

    // Basic sum, exact latency
    issue(1'b1, 1'b0, 28'd3, 18'd5, 38'd100, 1'b1, 2, 48'd115, 1'b0);
    idle(2);

    // Back-to-back with sub toggling
    issue(1'b1, 1'b1, 28'd2, 18'd2, 38'd10, 1'b1, 2, 48'd6, 1'b0);
    issue(1'b1, 1'b0, 28'd2, 18'd2, 38'd10, 1'b1, 2, 48'd14, 1'b0);
    idle(3);

    // Clock-enable freeze mid-stream
    issue(1'b1, 1'b0, 28'd7, 18'd9, 38'd1000, 1'b1, 2, 48'd1063, 1'b0);
    issue(1'b1, 1'b1, 28'd4, 18'd4, 38'd50, 1'b1, 2, 48'd34, 1'b0);
    for (int k = 0; k < 3; k++) issue(1'b0, 1'b0, '0, '0, '0, 1'b0, -1, '0, 1'b0);
    issue(1'b1, 1'b0, 28'd1, 18'd1, 38'd1, 1'b1, 2, 48'd2, 1'b0);
    idle(4);

    // Boundaries
    issue(1'b1, 1'b1, 28'd0, 18'd7, 38'd0, 1'b1, 2, 48'd0, 1'b0);
    issue(1'b1, 1'b1, 28'hFFF_FFFF, 18'h3_FFFF, 38'd0, 1'b1, 2, 48'hC000_1003_FFFF, 1'b0);
    issue(1'b1, 1'b1, 28'd0, 18'd0, 38'h3F_FFFF_FFFF, 1'b1, 2, 48'h003F_FFFF_FFFF, 1'b0);
    issue(1'b1, 1'b0, 28'h2_0000, 18'h2_0000, 38'h3F_FFFF_FFFF, 1'b1, 3, 48'h0003_FFFF_FC00, 1'b1);
    idle(5);

    // Async reset with samples in flight
    issue(1'b1, 1'b0, 28'd11, 18'd13, 38'd17, 1'b1, -1, '0, 1'b0);
    issue(1'b1, 1'b1, 28'd19, 18'd23, 38'd29, 1'b1, -1, '0, 1'b0);
    @(posedge clk); #1;
    v = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset", 1);
    for (int i = 0; i < 4; i++) sb[i].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);

    // Random sweep across all latencies
    for (int k = 0; k < 60; k++) begin
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 28'($urandom),
            18'($urandom), 38'({$urandom, $urandom}), 1'($urandom_range(0, 4) != 0), -1, '0, 1'b0);
    end
    idle(6);

    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (sb[i].size() != 0) begin
        n_fail++;
        $display("FAIL drain[L%0d]: got %0d samples outstanding, want 0", i, sb[i].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
